banked_spram_ctrl: RTL and testbench

BANKED_SPRAM_CTRL -- requirements
Module: banked_spram_ctrl

---
 rtl/banked_spram_ctrl_pkg.sv | 14 +
 rtl/banked_spram_ctrl_spram_bank.sv | 40 ++++
 rtl/banked_spram_ctrl.sv | 135 +++++++++++++
 tb/tb_banked_spram_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/banked_spram_ctrl_pkg.sv
// Shared bank power-state encoding and bank-select width helper.
// No logic here: constants and a constant function only.
package banked_spram_ctrl_pkg;

   localparam logic [1:0] BANK_ACTIVE  = 2'd0;
   localparam logic [1:0] BANK_STANDBY = 2'd1;
   localparam logic [1:0] BANK_WAKING  = 2'd2;

   // Number of upper address bits that pick a bank.
   function automatic int bank_sel_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

endpackage

// File: rtl/banked_spram_ctrl_spram_bank.sv
// One SPRAM bank: DW x 2^AW words with byte mask and standby input.
// One-cycle read latency; rdata_o holds until the next read; no backpressure.
module spram_bank #(
   parameter int DW = 32,
   parameter int AW = 14
) (
   input  logic            clk,
   input  logic            ce_i,
   input  logic            we_i,
   input  logic [DW/8-1:0] be_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   input  logic            standby_i,
   input  logic            sleep_i,
   input  logic            poweroff_i,
   output logic [DW-1:0]   rdata_o
);

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;
   logic          powered;

   // The array only responds when fully powered; contents are never reset.
   assign powered = !standby_i && !sleep_i && !poweroff_i;

   always_ff @(posedge clk) begin
      if (ce_i && powered) begin
         if (we_i) begin
            for (int i = 0; i < DW/8; i++) begin
               if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end else begin
            rdata_q <= mem[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_spram_ctrl.sv
// Banked SPRAM controller with per-bank idle standby and wake sequencing.
// Read data one cycle after acceptance; req_ready drops while the addressed bank is not ACTIVE.
module banked_spram_ctrl
   import banked_spram_ctrl_pkg::*;
#(
   parameter  int NUM_BANKS   = 4,
   parameter  int BANK_AW     = 14,
   parameter  int DW          = 32,
   parameter  int IDLE_CYCLES = 64,
   parameter  int WAKE_CYCLES = 3,
   localparam int BSW         = bank_sel_w(NUM_BANKS),
   localparam int AW          = BANK_AW + BSW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [AW-1:0]        req_addr,
   input  logic [DW-1:0]        req_wdata,
   input  logic [DW/8-1:0]      req_be,
   output logic                 rsp_valid,
   output logic [DW-1:0]        rsp_rdata,
   output logic [NUM_BANKS-1:0] bank_standby
);

   localparam int             IW        = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [IW-1:0]  IDLE_MAX  = IW'(IDLE_CYCLES);
   localparam logic [3:0]     WAKE_LAST = 4'(WAKE_CYCLES - 1);

   logic [BSW-1:0]       req_bank;
   logic [BANK_AW-1:0]   req_word;
   logic [NUM_BANKS-1:0] bank_active;
   logic                 accept;
   logic [DW-1:0]        bank_rdata [NUM_BANKS];

   logic                 rsp_vld_q;
   logic [BSW-1:0]       rsp_bank_q;
   logic [DW-1:0]        rsp_hold_q;

   assign req_bank  = req_addr[AW-1 -: BSW];
   assign req_word  = req_addr[BANK_AW-1:0];
   assign req_ready = bank_active[req_bank];
   assign accept    = req_valid && req_ready;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [1:0]      state_q, state_d;
      logic [IW-1:0]   idle_q, idle_d;
      logic [3:0]      wake_q, wake_d;
      logic            hit, acc;
      logic            bank_we;
      logic [DW/8-1:0] bank_be;

      assign hit = req_valid && (req_bank == BSW'(b));
      assign acc = accept && hit;

      // An access in the same cycle the counter saturates keeps the bank awake.
      always_comb begin
         state_d = state_q;
         idle_d  = '0;
         wake_d  = '0;
         case (state_q)
            BANK_ACTIVE: begin
               if (acc) begin
                  idle_d = '0;
               end else if ((IDLE_CYCLES != 0) && (idle_q == IDLE_MAX)) begin
                  state_d = BANK_STANDBY;
               end else if (idle_q != IDLE_MAX) begin
                  idle_d = idle_q + IW'(1);
               end else begin
                  idle_d = idle_q;
               end
            end
            BANK_STANDBY: begin
               if (hit) state_d = BANK_WAKING;
            end
            BANK_WAKING: begin
               if (wake_q == WAKE_LAST) state_d = BANK_ACTIVE;
               else                     wake_d  = wake_q + 4'd1;
            end
            default: state_d = BANK_ACTIVE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= BANK_ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
         end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
         end
      end

      assign bank_active[b]  = (state_q == BANK_ACTIVE);
      assign bank_standby[b] = !bank_active[b];
      assign bank_we         = acc && req_we;
      assign bank_be         = bank_we ? req_be : '0;

      spram_bank #(
         .DW (DW),
         .AW (BANK_AW)
      ) u_bank (
         .clk        (clk),
         .ce_i       (acc),
         .we_i       (bank_we),
         .be_i       (bank_be),
         .addr_i     (req_word),
         .wdata_i    (req_wdata),
         .standby_i  (!bank_active[b]),
         .sleep_i    (1'b0),
         .poweroff_i (1'b0),
         .rdata_o    (bank_rdata[b])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_vld_q  <= 1'b0;
         rsp_bank_q <= '0;
         rsp_hold_q <= '0;
      end else begin
         rsp_vld_q <= accept && !req_we;
         if (accept && !req_we) rsp_bank_q <= req_bank;
         if (rsp_vld_q)         rsp_hold_q <= bank_rdata[rsp_bank_q];
      end
   end

   // Reset in the response cycle suppresses the already-registered response.
   assign rsp_valid = rsp_vld_q && !reset;
   assign rsp_rdata = rsp_vld_q ? bank_rdata[rsp_bank_q] : rsp_hold_q;

endmodule

// File: tb/tb_banked_spram_ctrl.sv
// Directed bench: default-parameter controller plus a 2-bank, 16-bit instance.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_banked_spram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid1, req_ready1, req_we1, rsp_valid1;
   logic [15:0] req_addr1;
   logic [31:0] req_wdata1, rsp_rdata1;
   logic [3:0]  req_be1, bank_standby1;

   logic        req_valid2, req_ready2, req_we2, rsp_valid2;
   logic [14:0] req_addr2;
   logic [15:0] req_wdata2, rsp_rdata2;
   logic [1:0]  req_be2, bank_standby2;

   banked_spram_ctrl dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .bank_standby(bank_standby1)
   );

   banked_spram_ctrl #(.NUM_BANKS(2), .DW(16)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2), .req_be(req_be2),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .bank_standby(bank_standby2)
   );

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          exp_rsp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl[$];
   vec_t blank;
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
      vec_t v;
      v.we = 1'b1; v.addr = a; v.wdata = d; v.be = be; v.exp_rsp = 1'b0; v.exp_rdata = '0;
      return v;
   endfunction

   function automatic vec_t rd(input logic [15:0] a, input logic [31:0] exp);
      vec_t v;
      v.we = 1'b0; v.addr = a; v.wdata = '0; v.be = '0; v.exp_rsp = 1'b1; v.exp_rdata = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit d2, input bit v, input vec_t x);
      req_valid1 = 1'b0;
      req_valid2 = 1'b0;
      if (d2) begin
         req_valid2 = v; req_we2 = x.we; req_addr2 = x.addr[14:0];
         req_wdata2 = x.wdata[15:0]; req_be2 = x.be[1:0];
      end else begin
         req_valid1 = v; req_we1 = x.we; req_addr1 = x.addr;
         req_wdata1 = x.wdata; req_be1 = x.be;
      end
   endtask

   function automatic logic [31:0] f_rdata(input bit d2);
      return d2 ? {16'h0, rsp_rdata2} : rsp_rdata1;
   endfunction

   function automatic logic f_valid(input bit d2);
      return d2 ? rsp_valid2 : rsp_valid1;
   endfunction

   function automatic logic f_ready(input bit d2);
      return d2 ? req_ready2 : req_ready1;
   endfunction

   // One vector per cycle; each vector's response is checked in the following cycle.
   task automatic run_table(input bit d2);
      for (int i = 0; i <= tbl.size(); i++) begin
         if (i < tbl.size()) drive(d2, 1'b1, tbl[i]);
         else                drive(d2, 1'b0, blank);
         @(negedge clk);
         if (i < tbl.size()) chk($sformatf("tbl ready[%0d]", i), 32'(f_ready(d2)), 32'd1);
         if (i > 0) begin
            chk($sformatf("tbl rsp_valid[%0d]", i-1), 32'(f_valid(d2)), 32'(tbl[i-1].exp_rsp));
            if (tbl[i-1].exp_rsp)
               chk($sformatf("tbl rsp_rdata[%0d]", i-1), f_rdata(d2), tbl[i-1].exp_rdata);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, blank);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit got;
      int low;
      blank = wr(16'h0, 32'h0, 4'h0);
      reset = 1'b1;
      drive(1'b0, 1'b0, blank);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("reset rsp_valid", 32'(rsp_valid1), 32'd0);
      chk("reset rsp_rdata", rsp_rdata1, 32'h0);
      chk("reset bank_standby", 32'(bank_standby1), 32'h0);
      chk("reset req_ready", 32'(req_ready1), 32'd1);
      chk("reset bank_standby dut2", 32'(bank_standby2), 32'h0);
      @(posedge clk); #1;

      // Bank = addr[15:14]; word 5 in banks 0/3, word 9 in bank 1, word 5 in bank 2.
      tbl.delete();
      tbl.push_back(wr(16'h0005, 32'hDEADBEEF, 4'hF));
      tbl.push_back(wr(16'hC005, 32'h12345678, 4'hF));
      tbl.push_back(rd(16'h0005, 32'hDEADBEEF));
      tbl.push_back(rd(16'hC005, 32'h12345678));
      tbl.push_back(wr(16'h4009, 32'hFFFFFFFF, 4'hF));
      tbl.push_back(wr(16'h4009, 32'h000000AA, 4'b0001));
      tbl.push_back(rd(16'h4009, 32'hFFFFFFAA));
      tbl.push_back(wr(16'h0005, 32'h00000000, 4'b1100));
      tbl.push_back(rd(16'hC005, 32'h12345678));
      tbl.push_back(rd(16'h0005, 32'h0000BEEF));
      tbl.push_back(wr(16'h8005, 32'hCAFEF00D, 4'hF));
      tbl.push_back(wr(16'h8005, 32'h11223344, 4'h0));
      tbl.push_back(rd(16'h8005, 32'hCAFEF00D));
      tbl.push_back(rd(16'h0005, 32'h0000BEEF));
      run_table(1'b0);

      @(negedge clk);
      chk("hold rsp_valid", 32'(rsp_valid1), 32'd0);
      chk("hold rsp_rdata", rsp_rdata1, 32'h0000BEEF);
      @(posedge clk); #1;

      // Fresh reset: after 64 idle edges every counter sits at 64, bank 1 accessed then.
      do_reset();
      repeat (64) @(posedge clk);
      #1 drive(1'b0, 1'b1, rd(16'h4009, 32'h0));
      @(negedge clk);
      chk("cnt64 req_ready bank1", 32'(req_ready1), 32'd1);
      chk("cnt64 bank_standby", 32'(bank_standby1), 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, blank);
      @(negedge clk);
      chk("cnt64 rsp_valid", 32'(rsp_valid1), 32'd1);
      chk("cnt64 rsp_rdata", rsp_rdata1, 32'hFFFFFFAA);
      chk("cnt64 standby others", 32'(bank_standby1), 32'h0000000D);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bank1 stays active", 32'(bank_standby1[1]), 32'd0);
      @(posedge clk); #1;

      // Wake bank 2: four stalled cycles, accept on the fifth.
      drive(1'b0, 1'b1, rd(16'h8005, 32'h0));
      got = 1'b0;
      low = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready1) got = 1'b1;
         else begin
            low++;
            @(posedge clk); #1;
         end
      end
      chk("wake accepted", 32'(got), 32'd1);
      chk("wake stall cycles", 32'(low), 32'd4);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, blank);
      @(negedge clk);
      chk("wake rsp_valid", 32'(rsp_valid1), 32'd1);
      chk("wake rsp_rdata", rsp_rdata1, 32'hCAFEF00D);
      chk("wake bank_standby", 32'(bank_standby1), 32'h00000009);
      @(posedge clk); #1;

      // Reset lands in the response cycle of an accepted read.
      drive(1'b0, 1'b1, rd(16'h4009, 32'h0));
      @(negedge clk);
      chk("midread req_ready", 32'(req_ready1), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, blank);
      @(negedge clk);
      chk("midread rsp_valid in reset", 32'(rsp_valid1), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midread rsp_valid after", 32'(rsp_valid1), 32'd0);
      chk("midread bank_standby", 32'(bank_standby1), 32'h0);
      chk("midread rsp_rdata", rsp_rdata1, 32'h0);
      @(posedge clk); #1;

      // Memory survives reset.
      tbl.delete();
      tbl.push_back(rd(16'h4009, 32'hFFFFFFAA));
      tbl.push_back(rd(16'hC005, 32'h12345678));
      run_table(1'b0);

      // 2 banks x 16 bits: bank = addr[14].
      tbl.delete();
      tbl.push_back(wr(16'h0005, 32'h0000BEEF, 4'h3));
      tbl.push_back(wr(16'h4005, 32'h00005678, 4'h3));
      tbl.push_back(rd(16'h0005, 32'h0000BEEF));
      tbl.push_back(rd(16'h4005, 32'h00005678));
      tbl.push_back(wr(16'h4009, 32'h0000FFFF, 4'h3));
      tbl.push_back(wr(16'h4009, 32'h000000AA, 4'h1));
      tbl.push_back(rd(16'h4009, 32'h0000FFAA));
      run_table(1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
